// File: rtl/trigger_seq_pkg.sv
// Shared constants and types for the multi-stage trigger sequencer.
package trigger_seq_pkg;

  localparam int unsigned CFG_W         = 32;
  localparam int unsigned LVL_W         = 2;
  localparam int unsigned CH_W          = 5;
  localparam int unsigned DLY_MAX_W     = 16;

  // Bit positions of the fields inside a cfg write payload
  localparam int unsigned CFG_DLY_LSB   = 0;
  localparam int unsigned CFG_DLY_MSB   = 15;
  localparam int unsigned CFG_LVL_LSB   = 16;
  localparam int unsigned CFG_LVL_MSB   = 17;
  localparam int unsigned CFG_CH_LSB    = 20;
  localparam int unsigned CFG_CH_MSB    = 24;
  localparam int unsigned CFG_SER_BIT   = 26;
  localparam int unsigned CFG_START_BIT = 27;

  // Decoded per-stage configuration (reserved payload bits are not stored)
  typedef struct packed {
    logic                 start;
    logic                 serial;
    logic [CH_W-1:0]      channel;
    logic [LVL_W-1:0]     level;
    logic [DLY_MAX_W-1:0] delay;
  } stage_cfg_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_DELAY = 2'd2,
    ST_FIRED = 2'd3
  } seq_state_t;

  // Level increment that saturates at the top level
  function automatic logic [LVL_W-1:0] level_inc(input logic [LVL_W-1:0] lvl);
    return (lvl == '1) ? lvl : lvl + LVL_W'(1);
  endfunction

endpackage

// File: rtl/trigger_seq_if.sv
// Command/sample/status bundle between the command decoder and the trigger.
interface trigger_seq_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
);
  localparam int unsigned STG_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic [31:0]       cmd_i;
  logic              set_mask_i;
  logic              set_val_i;
  logic              set_cfg_i;
  logic [STG_W-1:0]  stg_i;
  logic              arm_i;
  logic              disarm_i;
  logic              stb_i;
  logic [WIDTH-1:0]  smpls_i;
  logic              run_o;
  logic              armed_o;
  logic [1:0]        level_o;

  modport master (
    output cmd_i, set_mask_i, set_val_i, set_cfg_i, stg_i,
    output arm_i, disarm_i, stb_i, smpls_i,
    input  run_o, armed_o, level_o
  );

  modport slave (
    input  cmd_i, set_mask_i, set_val_i, set_cfg_i, stg_i,
    input  arm_i, disarm_i, stb_i, smpls_i,
    output run_o, armed_o, level_o
  );
endinterface

// File: rtl/trigger_seq_stage.sv
// One trigger stage: mask/value/cfg storage, serial shift register, match.
module trigger_seq_stage
  import trigger_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CFG_W-1:0]     cmd,
  input  logic                 wr_mask,
  input  logic                 wr_val,
  input  logic                 wr_cfg,
  input  logic                 sh_clr,
  input  logic                 sh_en,
  input  logic [WIDTH-1:0]     smpls,
  output logic                 match_c,
  output logic                 start,
  output logic [LVL_W-1:0]     level,
  output logic [DLY_MAX_W-1:0] delay
);

  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_nxt;
  logic [WIDTH-1:0] data;
  logic [31:0]      smpls_ext;
  logic             ser_bit;
  stage_cfg_t       cfg_q;
  stage_cfg_t       cfg_wr;
  logic             unused_cmd;

  // Reserved payload bits have no storage in a stage
  assign unused_cmd = ^{cmd[31:28], cmd[25], cmd[19:18]};

  // Field extraction of a cfg payload
  always_comb begin
    cfg_wr         = '0;
    cfg_wr.delay   = cmd[CFG_DLY_MSB:CFG_DLY_LSB];
    cfg_wr.level   = cmd[CFG_LVL_MSB:CFG_LVL_LSB];
    cfg_wr.channel = cmd[CFG_CH_MSB:CFG_CH_LSB];
    cfg_wr.serial  = cmd[CFG_SER_BIT];
    cfg_wr.start   = cmd[CFG_START_BIT];
  end

  // Match evaluation; serial data already includes this strobe's shift
  always_comb begin
    smpls_ext = 32'(smpls);
    ser_bit   = 1'b0;
    if (32'(cfg_q.channel) < WIDTH) ser_bit = smpls_ext[cfg_q.channel];
    sh_nxt    = WIDTH'({sh_q, ser_bit});
    data      = cfg_q.serial ? sh_nxt : smpls;
    match_c   = ((data ^ val_q) & mask_q) == '0;
  end

  // Configuration registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_q <= '0;
      val_q  <= '0;
      cfg_q  <= '0;
    end else begin
      if (wr_mask) mask_q <= cmd[WIDTH-1:0];
      if (wr_val)  val_q  <= cmd[WIDTH-1:0];
      if (wr_cfg)  cfg_q  <= cfg_wr;
    end
  end

  // Serial shift register, cleared on arm, shifted per strobe while armed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      sh_q <= '0;
    else if (sh_clr) sh_q <= '0;
    else if (sh_en)  sh_q <= sh_nxt;
  end

  assign start = cfg_q.start;
  assign level = cfg_q.level;
  assign delay = cfg_q.delay;

endmodule

// File: rtl/trigger_seq.sv
// Multi-stage, multi-level trigger with strobe-counted start delay.
module trigger_seq
  import trigger_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned DLY_W  = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  trigger_seq_if.slave bus
);

  localparam int unsigned STG_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  seq_state_t           state_q;
  seq_state_t           state_nxt;
  logic [LVL_W-1:0]     level_q;
  logic [LVL_W-1:0]     level_nxt;
  logic [DLY_W-1:0]     cnt_q;
  logic [DLY_W-1:0]     cnt_nxt;
  logic                 run_q;
  logic                 armed_q;

  logic                 wr_ok_c;
  logic                 arm_c;
  logic [STAGES-1:0]    match_s;
  logic [STAGES-1:0]    start_s;
  logic [LVL_W-1:0]     lvl_s [STAGES];
  logic [DLY_MAX_W-1:0] dly_s [STAGES];
  logic [STAGES-1:0]    hit_c;
  logic                 any_hit_c;
  logic                 start_hit_c;
  logic [DLY_W-1:0]     load_dly_c;

  // Config writes only while disarmed and for an existing stage
  assign wr_ok_c = !armed_q && (32'(bus.stg_i) < STAGES);
  assign arm_c   = bus.arm_i && !bus.disarm_i;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    trigger_seq_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .cmd     (bus.cmd_i),
      .wr_mask (bus.set_mask_i && wr_ok_c && (bus.stg_i == STG_W'(s))),
      .wr_val  (bus.set_val_i  && wr_ok_c && (bus.stg_i == STG_W'(s))),
      .wr_cfg  (bus.set_cfg_i  && wr_ok_c && (bus.stg_i == STG_W'(s))),
      .sh_clr  (arm_c),
      .sh_en   (bus.stb_i && armed_q),
      .smpls   (bus.smpls_i),
      .match_c (match_s[s]),
      .start   (start_s[s]),
      .level   (lvl_s[s]),
      .delay   (dly_s[s])
    );
  end

  // Active-stage hits and lowest-index start-stage priority encoder
  always_comb begin
    hit_c       = '0;
    start_hit_c = 1'b0;
    load_dly_c  = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      hit_c[s] = bus.stb_i && (state_q == ST_MATCH) && match_s[s] && (lvl_s[s] == level_q);
      if (hit_c[s] && start_s[s] && !start_hit_c) begin
        start_hit_c = 1'b1;
        load_dly_c  = DLY_W'(dly_s[s]);
      end
    end
    any_hit_c = |hit_c;
  end

  // State, sequencer and status registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      level_q <= level_nxt;
      cnt_q   <= cnt_nxt;
      run_q   <= (state_nxt == ST_FIRED);
      armed_q <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state: disarm beats arm, both beat the sequencing
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  state_nxt = ST_IDLE;
      ST_MATCH: if (start_hit_c) state_nxt = (load_dly_c == '0) ? ST_FIRED : ST_DELAY;
      ST_DELAY: if (bus.stb_i && (cnt_q == DLY_W'(1))) state_nxt = ST_FIRED;
      ST_FIRED: state_nxt = ST_FIRED;
      default:  state_nxt = ST_IDLE;
    endcase
    if (bus.disarm_i)   state_nxt = ST_IDLE;
    else if (bus.arm_i) state_nxt = ST_MATCH;
  end

  // Level sequencer and delay counter updates
  always_comb begin
    level_nxt = level_q;
    cnt_nxt   = cnt_q;
    if (state_q == ST_MATCH && start_hit_c)      cnt_nxt   = load_dly_c;
    else if (state_q == ST_MATCH && any_hit_c)   level_nxt = level_inc(level_q);
    else if (state_q == ST_DELAY && bus.stb_i)   cnt_nxt   = cnt_q - DLY_W'(1);
    if (bus.disarm_i || bus.arm_i) begin
      level_nxt = '0;
      cnt_nxt   = '0;
    end
  end

  assign bus.run_o   = run_q;
  assign bus.armed_o = armed_q;
  assign bus.level_o = level_q;

endmodule

// File: tb/tb_trigger_seq.sv
// Directed, table-driven bench for trigger_seq.
module tb_trigger_seq;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 5;
  localparam int unsigned DLY_W  = 16;
  localparam int unsigned STG_W  = $clog2(STAGES);

  logic clk = 1'b0;
  logic rst;

  trigger_seq_if #(.WIDTH(WIDTH), .STAGES(STAGES)) bus ();

  trigger_seq #(.WIDTH(WIDTH), .STAGES(STAGES), .DLY_W(DLY_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          seg;
    logic        stb;
    logic [31:0] smpls;
    logic        run;
    logic        armed;
    logic [1:0]  level;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic run, input logic armed, input logic [1:0] level);
    check({name, ".run"},   32'(bus.run_o),   32'(run));
    check({name, ".armed"}, 32'(bus.armed_o), 32'(armed));
    check({name, ".level"}, 32'(bus.level_o), 32'(level));
  endtask

  function automatic logic [31:0] mkcfg(input int start, input int serial, input int ch,
                                        input int lvl, input int dly);
    return (32'(start & 1) << 27) | (32'(serial & 1) << 26) | (32'(ch & 31) << 20) |
           (32'(lvl & 3) << 16) | 32'(dly & 16'hFFFF);
  endfunction

  task automatic wr(input logic m, input logic v, input logic c, input int stg, input logic [31:0] data);
    bus.set_mask_i = m;
    bus.set_val_i  = v;
    bus.set_cfg_i  = c;
    bus.stg_i      = STG_W'(stg);
    bus.cmd_i      = data;
    tick();
    bus.set_mask_i = 1'b0;
    bus.set_val_i  = 1'b0;
    bus.set_cfg_i  = 1'b0;
  endtask

  task automatic stage(input int s, input logic [31:0] mask, input logic [31:0] val, input logic [31:0] cfg);
    wr(1'b1, 1'b0, 1'b0, s, mask);
    wr(1'b0, 1'b1, 1'b0, s, val);
    wr(1'b0, 1'b0, 1'b1, s, cfg);
  endtask

  // Every stage set to a pattern the stimulus never produces
  task automatic all_idle();
    for (int s = 0; s < int'(STAGES); s++) stage(s, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0);
  endtask

  task automatic arm();
    bus.arm_i = 1'b1;
    tick();
    bus.arm_i = 1'b0;
  endtask

  task automatic disarm();
    bus.disarm_i = 1'b1;
    tick();
    bus.disarm_i = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] d);
    bus.stb_i   = 1'b1;
    bus.smpls_i = d;
    tick();
    bus.stb_i   = 1'b0;
  endtask

  task automatic apply_seg(input int seg);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].seg == seg) begin
        bus.stb_i   = vecs[i].stb;
        bus.smpls_i = vecs[i].smpls;
        tick();
        bus.stb_i   = 1'b0;
        check_outs($sformatf("seg%0d_v%0d", seg, i), vecs[i].run, vecs[i].armed, vecs[i].level);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.cmd_i      = '0;
    bus.set_mask_i = 1'b0;
    bus.set_val_i  = 1'b0;
    bus.set_cfg_i  = 1'b0;
    bus.stg_i      = '0;
    bus.arm_i      = 1'b0;
    bus.disarm_i   = 1'b0;
    bus.stb_i      = 1'b0;
    bus.smpls_i    = '0;

    // seg0: parallel, start, delay 0
    vecs.push_back('{0, 1'b1, 32'h00, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{0, 1'b1, 32'h5B, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{0, 1'b1, 32'h5A, 1'b1, 1'b1, 2'd0});
    vecs.push_back('{0, 1'b0, 32'h00, 1'b1, 1'b1, 2'd0});
    vecs.push_back('{0, 1'b1, 32'h5A, 1'b1, 1'b1, 2'd0});
    // seg1: delay 3 with idle gaps; a 0x5A inside the delay does not reload
    vecs.push_back('{1, 1'b1, 32'h5A, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{1, 1'b0, 32'h00, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{1, 1'b1, 32'h00, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{1, 1'b0, 32'h00, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{1, 1'b0, 32'h00, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{1, 1'b1, 32'h5A, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{1, 1'b1, 32'h22, 1'b1, 1'b1, 2'd0});
    vecs.push_back('{1, 1'b0, 32'h00, 1'b1, 1'b1, 2'd0});
    // seg2: two-level sequence
    vecs.push_back('{2, 1'b1, 32'h02, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{2, 1'b1, 32'h01, 1'b0, 1'b1, 2'd1});
    vecs.push_back('{2, 1'b1, 32'h02, 1'b1, 1'b1, 2'd1});
    vecs.push_back('{2, 1'b0, 32'h00, 1'b1, 1'b1, 2'd1});
    // seg3: mask=0 on levels 0..3, level saturates at 3
    vecs.push_back('{3, 1'b1, 32'h11, 1'b0, 1'b1, 2'd1});
    vecs.push_back('{3, 1'b0, 32'h00, 1'b0, 1'b1, 2'd1});
    vecs.push_back('{3, 1'b1, 32'h22, 1'b0, 1'b1, 2'd2});
    vecs.push_back('{3, 1'b1, 32'h33, 1'b0, 1'b1, 2'd3});
    vecs.push_back('{3, 1'b1, 32'h44, 1'b0, 1'b1, 2'd3});
    // seg4: serial on channel 3, pattern 1,0,1,0 -> 0xA
    vecs.push_back('{4, 1'b1, 32'h08, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{4, 1'b1, 32'h00, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{4, 1'b1, 32'h08, 1'b0, 1'b1, 2'd0});
    vecs.push_back('{4, 1'b1, 32'h00, 1'b1, 1'b1, 2'd0});

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    tick();

    all_idle();
    stage(0, 32'hFF, 32'h5A, mkcfg(1, 0, 0, 0, 0));
    arm();
    check_outs("arm", 1'b0, 1'b1, 2'd0);
    apply_seg(0);

    disarm();
    check_outs("disarm_fired", 1'b0, 1'b0, 2'd0);
    wr(1'b0, 1'b0, 1'b1, 0, mkcfg(1, 0, 0, 0, 3));
    arm();
    apply_seg(1);

    disarm();
    stage(0, 32'hFF, 32'h01, mkcfg(0, 0, 0, 0, 0));
    stage(1, 32'hFF, 32'h02, mkcfg(1, 0, 0, 1, 0));
    arm();
    apply_seg(2);

    disarm();
    for (int s = 0; s < 4; s++) stage(s, 32'h0, 32'h0, mkcfg(0, 0, 0, s, 0));
    arm();
    apply_seg(3);

    disarm();
    all_idle();
    stage(0, 32'hF, 32'hA, mkcfg(1, 1, 3, 0, 0));
    arm();
    apply_seg(4);

    // Asynchronous reset mid-delay clears outputs and configuration
    disarm();
    all_idle();
    stage(0, 32'hFF, 32'h5A, mkcfg(1, 0, 0, 0, 10));
    arm();
    strobe(32'h5A);
    repeat (4) strobe(32'h0);
    check_outs("pre_rst", 1'b0, 1'b1, 2'd0);
    rst = 1'b1;
    #1;
    check_outs("rst_async", 1'b0, 1'b0, 2'd0);
    tick();
    rst = 1'b0;
    arm();
    strobe(32'h1234_5678);
    check_outs("post_rst_cfg_zero", 1'b0, 1'b1, 2'd1);

    // Disarm mid-delay keeps configuration; re-arm runs the full delay
    disarm();
    all_idle();
    stage(0, 32'hFF, 32'h5A, mkcfg(1, 0, 0, 0, 10));
    arm();
    strobe(32'h5A);
    repeat (5) strobe(32'h0);
    disarm();
    check_outs("disarm_mid", 1'b0, 1'b0, 2'd0);
    arm();
    check_outs("rearm", 1'b0, 1'b1, 2'd0);
    strobe(32'h5A);
    repeat (9) strobe(32'h0);
    check_outs("dly9", 1'b0, 1'b1, 2'd0);
    strobe(32'h0);
    check_outs("dly10", 1'b1, 1'b1, 2'd0);

    // Write protection: while armed, and for an out-of-range stage index
    wr(1'b0, 1'b1, 1'b0, 0, 32'h0);
    disarm();
    check_outs("disarm_run", 1'b0, 1'b0, 2'd0);
    wr(1'b0, 1'b0, 1'b1, 0, mkcfg(1, 0, 0, 0, 0));
    wr(1'b1, 1'b1, 1'b1, 5, 32'h0800_0000);
    arm();
    strobe(32'h0800_0000);
    check_outs("oob_write_dropped", 1'b0, 1'b1, 2'd0);
    strobe(32'h0);
    check_outs("armed_write_dropped", 1'b0, 1'b1, 2'd0);
    strobe(32'h5A);
    check_outs("cfg_intact", 1'b1, 1'b1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
